fpu_pack_s2h_x4: RTL and testbench
==================================

FPU_PACK_S2H_X4 -- requirements
Module: fpu_pack_s2h_x4

Interface
REQ-001 Parameter: none; lane count fixed at 4, lane width fixed at 16.
REQ-002 clock  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  upstream presents a binary32 word.
REQ-005 in_ready  out  1  block accepts word this cycle (transfer = in_valid && in_ready).
REQ-006 in_data  in  32  binary32 source value.
REQ-007 in_last  in  1  accepted word closes the current group (flush partial).
REQ-008 out_valid  out  1  packed group held in output register.
REQ-009 out_ready  in  1  downstream consumes group (transfer = out_valid && out_ready).
REQ-010 out_data  out  64  packed binary16 lanes, lane n at bits [16n+15:16n].
REQ-011 out_mask  out  4  bit n set = lane n filled.
REQ-012 out_sat  out  4  bit n set = lane n clamped to exponent 0x1F.

Function
REQ-013 Conversion: let s=in_data[31], m=in_data[22:13]; if in_data[30:26] is 0x0F or 0x10, half = {s, in_data[30], in_data[26:23], m}.
REQ-014 Else if in_data[30]=1: half = {s, 5'h1F, m}, lane sat flag = 1.
REQ-015 Else (in_data[30]=0): half = {1'b0, 5'h00, m}; sign forced 0, sat flag 0.
REQ-016 Mantissa truncated (no rounding); no NaN/Inf special-casing beyond REQ-013..015.
REQ-017 Lane counter (2 bits) selects write lane; lane 0 written first.
REQ-018 Accepted word writes its half into assembly buffer at current lane, sets that mask bit and sat bit.
REQ-019 Group completes when accepted word lands in lane 3 or in_last=1.
REQ-020 On completion: assembly buffer (incl. completing lane) moves to output register next edge; out_valid=1; counter, buffer, mask, sat cleared to 0.
REQ-021 Unfilled lanes of a completed group SHALL read 16'h0000 in out_data.
REQ-022 Latency: out_valid rises on the edge following acceptance of the completing word.
REQ-023 in_ready = !out_valid || out_ready (combinational); stall only when output register full and not draining.
REQ-024 Non-completing words SHALL be accepted regardless of output register state? No: in_ready per REQ-023 applies to all words (single rule).
REQ-025 Simultaneous out transfer and completion: output register reloads same edge, out_valid stays 1, no bubble.
REQ-026 out transfer without completion: out_valid falls next edge.
REQ-027 out_data, out_mask, out_sat SHALL stay stable while out_valid && !out_ready.
REQ-028 in_valid=0 SHALL not change buffer or counter; in_last ignored unless transfer occurs.
REQ-029 in_last on lane 3 word: single completion, identical to REQ-019.

Reset
REQ-030 Reset SHALL force in_ready=1, out_valid=0, out_data=0, out_mask=0, out_sat=0, counter=0, buffer=0.
REQ-031 Reset mid-group SHALL discard partial group and any unconsumed output; no output after release until a new group completes.

Structure
REQ-032 Shared package holds lane-count constant (4), lane-width constant (16), half exponent-max constant (5'h1F).
REQ-033 Conversion (REQ-013..016) SHALL be one combinational sub-module fpu_cvt_s2h_lane (32-bit in, 16-bit half + sat flag out), instantiated once.
REQ-034 Sequential part: lane counter, assembly buffer, output register; no other state.

Verification
REQ-035 Four words 0x3F800000, 0xBF800000, 0x40000000, 0x3F000000, out_ready=1 -> one group, out_data=0x3800_4000_BC00_3C00, mask=0xF, sat=0x0.
REQ-036 Word 0x47800000 (65536.0) then 0x2EDBE6FF with in_last -> out_data lanes 0=0x7C00, 1=0x02DF, 2..3=0x0000; mask=0x3, sat=0x1.
REQ-037 out_ready held 0 after group complete -> in_ready=0 after 0 further accepts once out_valid, out_data stable 10 cycles; release -> next group proceeds, no word lost or duplicated.
REQ-038 Continuous in_valid=1, out_ready=1, 16 words -> 4 groups, back-to-back, in_ready never drops.
REQ-039 Assert reset after 2 words accepted -> out_valid=0, counter=0; next 4 words form group with mask=0xF containing only post-reset data.

Source files
------------

// File: rtl/fpu_pack_s2h_x4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pack_s2h_x4_pkg
// Description : Shared lane geometry and binary16 constants for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pack_s2h_x4_pkg;

    localparam int          c_LANE_COUNT   = 4;
    localparam int          c_LANE_WIDTH   = 16;
    localparam logic [4:0]  c_HALF_EXP_MAX = 5'h1F;

    typedef logic [c_LANE_WIDTH-1:0] half_t;
    typedef logic [$clog2(c_LANE_COUNT)-1:0] lane_t;

    localparam lane_t c_LAST_LANE = lane_t'(c_LANE_COUNT - 1);

endpackage
`default_nettype wire

// File: rtl/fpu_pack_s2h_x4_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pack_s2h_x4_if
// Description : Input word stream and packed output group stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_pack_s2h_x4_if;
    import fpu_pack_s2h_x4_pkg::*;

    logic                                 inValid;
    logic                                 inReady;
    logic [31:0]                          inData;
    logic                                 inLast;
    logic                                 outValid;
    logic                                 outReady;
    logic [c_LANE_COUNT*c_LANE_WIDTH-1:0] outData;
    logic [c_LANE_COUNT-1:0]              outMask;
    logic [c_LANE_COUNT-1:0]              outSat;

    modport master (
        output inValid, inData, inLast, outReady,
        input  inReady, outValid, outData, outMask, outSat
    );

    modport slave (
        input  inValid, inData, inLast, outReady,
        output inReady, outValid, outData, outMask, outSat
    );
endinterface
`default_nettype wire

// File: rtl/fpu_cvt_s2h_lane.sv
`default_nettype none
// ============================================================================
// Module      : fpu_cvt_s2h_lane
// Description : Combinational binary32 -> binary16 truncating converter.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_cvt_s2h_lane
    import fpu_pack_s2h_x4_pkg::*;
(
    input  logic [31:0] i_word,
    output half_t       o_half,
    output logic        o_sat
);

    logic       w_sign;
    logic [9:0] w_mant;
    logic       w_unusedLsbs;

    assign w_sign       = i_word[31];
    assign w_mant       = i_word[22:13];
    assign w_unusedLsbs = ^i_word[12:0];

    // Only exponents 0x78..0x87 map directly; above saturates, below flushes to +0.
    always_comb begin
        o_sat  = 1'b0;
        o_half = {1'b0, 5'h00, w_mant};
        if (i_word[30:26] == 5'h0F || i_word[30:26] == 5'h10) begin
            o_half = {w_sign, i_word[30], i_word[26:23], w_mant};
        end else if (i_word[30]) begin
            o_half = {w_sign, c_HALF_EXP_MAX, w_mant};
            o_sat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_pack_s2h_x4.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pack_s2h_x4
// Description : Converts binary32 words to binary16 and packs four per group.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_pack_s2h_x4
    import fpu_pack_s2h_x4_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    fpu_pack_s2h_x4_if.slave         bus
);

    lane_t                          r_lane;
    half_t [c_LANE_COUNT-1:0]       r_buf;
    logic  [c_LANE_COUNT-1:0]       r_mask;
    logic  [c_LANE_COUNT-1:0]       r_sat;
    half_t [c_LANE_COUNT-1:0]       r_outData;
    logic  [c_LANE_COUNT-1:0]       r_outMask;
    logic  [c_LANE_COUNT-1:0]       r_outSat;
    logic                           r_outValid;

    half_t                          w_half;
    logic                           w_sat;
    logic                           w_accept;
    logic                           w_complete;
    half_t [c_LANE_COUNT-1:0]       w_nextBuf;
    logic  [c_LANE_COUNT-1:0]       w_nextMask;
    logic  [c_LANE_COUNT-1:0]       w_nextSat;

    fpu_cvt_s2h_lane u_cvt (
        .i_word (bus.inData),
        .o_half (w_half),
        .o_sat  (w_sat)
    );

    assign bus.inReady  = !r_outValid || bus.outReady;
    assign bus.outValid = r_outValid;
    assign bus.outData  = r_outData;
    assign bus.outMask  = r_outMask;
    assign bus.outSat   = r_outSat;

    assign w_accept   = bus.inValid && bus.inReady;
    assign w_complete = w_accept && (r_lane == c_LAST_LANE || bus.inLast);

    // Buffer as it looks with the current word merged, so a completing lane is included.
    always_comb begin
        w_nextBuf          = r_buf;
        w_nextMask         = r_mask;
        w_nextSat          = r_sat;
        w_nextBuf[r_lane]  = w_half;
        w_nextMask[r_lane] = 1'b1;
        w_nextSat[r_lane]  = w_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane     <= '0;
            r_buf      <= '0;
            r_mask     <= '0;
            r_sat      <= '0;
            r_outData  <= '0;
            r_outMask  <= '0;
            r_outSat   <= '0;
            r_outValid <= 1'b0;
        end else if (w_complete) begin
            r_outData  <= w_nextBuf;
            r_outMask  <= w_nextMask;
            r_outSat   <= w_nextSat;
            r_outValid <= 1'b1;
            r_lane     <= '0;
            r_buf      <= '0;
            r_mask     <= '0;
            r_sat      <= '0;
        end else begin
            if (w_accept) begin
                r_buf  <= w_nextBuf;
                r_mask <= w_nextMask;
                r_sat  <= w_nextSat;
                r_lane <= r_lane + lane_t'(1);
            end
            if (r_outValid && bus.outReady) begin
                r_outValid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_pack_s2h_x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_pack_s2h_x4
// Description : Directed vector bench for the binary32 -> binary16 x4 packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_pack_s2h_x4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_pack_s2h_x4_if bus ();

    fpu_pack_s2h_x4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0][31:0] w;
        int               n;
        logic             lastOnFinal;
        logic [63:0]      expData;
        logic [3:0]       expMask;
        logic [3:0]       expSat;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  m;
        logic [3:0]  s;
    } grp_t;

    vec_t vecs[4];
    grp_t q[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   readyDrops = 0;
    logic trackReady = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transfers are observed mid-cycle, where handshake signals are settled.
    always @(negedge clk) begin
        if (!rst && bus.outValid && bus.outReady) begin
            q.push_back('{d: bus.outData, m: bus.outMask, s: bus.outSat});
        end
        if (trackReady && !bus.inReady) readyDrops++;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic sendWord(input logic [31:0] w, input logic last);
        int t = 0;
        bus.inValid = 1'b1;
        bus.inData  = w;
        bus.inLast  = last;
        @(negedge clk);
        while (!bus.inReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.inReady) begin
            nChecks++;
            nFail++;
            $display("FAIL accept timeout: word %0h never accepted", w);
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        bus.inLast  = 1'b0;
    endtask

    task automatic waitQ(input int n);
        int t = 0;
        while (q.size() < n && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("group count", 64'(q.size()), 64'(n));
    endtask

    task automatic popChk(input string nm, input logic [63:0] d, input logic [3:0] m, input logic [3:0] s);
        grp_t g;
        if (q.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL %s: no group received, expected data %0h", nm, d);
        end else begin
            g = q.pop_front();
            chk({nm, " data"}, g.d, d);
            chk({nm, " mask"}, 64'(g.m), 64'(m));
            chk({nm, " sat"},  64'(g.s), 64'(s));
        end
    endtask

    task automatic setVec(input int i, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3, input int n,
                          input logic lastF, input logic [63:0] d, input logic [3:0] m,
                          input logic [3:0] s);
        vecs[i].w           = {w3, w2, w1, w0};
        vecs[i].n           = n;
        vecs[i].lastOnFinal = lastF;
        vecs[i].expData     = d;
        vecs[i].expMask     = m;
        vecs[i].expSat      = s;
    endtask

    initial begin
        logic [63:0] expD;
        logic [63:0] heldD;

        setVec(0, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3F000000, 4, 1'b0,
               64'h3800_4000_BC00_3C00, 4'hF, 4'h0);
        setVec(1, 32'h47800000, 32'h2EDBE6FF, 32'h0, 32'h0, 2, 1'b1,
               64'h0000_0000_02DF_7C00, 4'h3, 4'h1);
        setVec(2, 32'hC0000000, 32'h80000001, 32'hFF800000, 32'h0, 3, 1'b1,
               64'h0000_FC00_0000_C000, 4'h7, 4'h4);
        setVec(3, 32'h3FFFFFFF, 32'h477FE000, 32'h43000000, 32'h3C000000, 4, 1'b1,
               64'h2000_5800_7FFF_3FFF, 4'hF, 4'h2);

        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.inLast   = 1'b0;
        bus.outReady = 1'b1;

        @(posedge clk);
        #1;
        chk("reset outValid", 64'(bus.outValid), 64'd0);
        chk("reset inReady",  64'(bus.inReady),  64'd1);
        chk("reset outData",  bus.outData,       64'd0);
        chk("reset outMask",  64'(bus.outMask),  64'd0);
        chk("reset outSat",   64'(bus.outSat),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: each record is one group; a stray inLast without inValid follows word 0.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                sendWord(vecs[v].w[k], (k == vecs[v].n - 1) ? vecs[v].lastOnFinal : 1'b0);
                if (k == 0 && vecs[v].n > 1) begin
                    bus.inLast = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.inLast = 1'b0;
                end
            end
            chk($sformatf("vec%0d outValid latency", v), 64'(bus.outValid), 64'd1);
            chk($sformatf("vec%0d outData", v), bus.outData, vecs[v].expData);
            waitQ(1);
            popChk($sformatf("vec%0d", v), vecs[v].expData, vecs[v].expMask, vecs[v].expSat);
            chk($sformatf("vec%0d outValid falls", v), 64'(bus.outValid), 64'd0);
        end

        // Backpressure: group A held while word B0 waits at the input.
        bus.outReady = 1'b0;
        for (int k = 0; k < 4; k++) sendWord(32'h3F800000, 1'b0);
        heldD = 64'h3C00_3C00_3C00_3C00;
        bus.inValid = 1'b1;
        bus.inData  = 32'h40000000;
        bus.inLast  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall inReady", 64'(bus.inReady), 64'd0);
            chk("stall outData", bus.outData, heldD);
        end
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        sendWord(32'hBF800000, 1'b0);
        sendWord(32'h3F000000, 1'b0);
        sendWord(32'hC0000000, 1'b0);
        waitQ(2);
        popChk("stall A", heldD, 4'hF, 4'h0);
        popChk("stall B", 64'hC000_3800_BC00_4000, 4'hF, 4'h0);

        // Streaming: 16 words, lane value encodes the word index in its mantissa.
        trackReady = 1'b1;
        for (int i = 0; i < 16; i++) sendWord(32'h3F800000 | (32'(i) << 13), 1'b0);
        waitQ(4);
        trackReady = 1'b0;
        chk("stream inReady drops", 64'(readyDrops), 64'd0);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) expD[16*k +: 16] = 16'h3C00 | 16'(4*g + k);
            popChk($sformatf("stream g%0d", g), expD, 4'hF, 4'h0);
        end

        // Reset mid-group discards the two words already buffered.
        sendWord(32'hC0000000, 1'b0);
        sendWord(32'hC0000000, 1'b0);
        rst = 1'b1;
        #1;
        chk("midreset outValid", 64'(bus.outValid), 64'd0);
        chk("midreset inReady",  64'(bus.inReady),  64'd1);
        chk("midreset outMask",  64'(bus.outMask),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendWord(32'h3F800000, 1'b0);
        sendWord(32'h40000000, 1'b0);
        sendWord(32'h3F000000, 1'b0);
        sendWord(32'hBF800000, 1'b0);
        waitQ(1);
        popChk("post-reset", 64'hBC00_3800_4000_3C00, 4'hF, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("post-reset extra groups", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
